// File: rtl/aes_trace_pkg.sv
// aes_trace_pkg: shared types and constants for the AES trace framer.
//   state_t             framer FSM states (IDLE, WAIT, SEND)
//   HDR_BYTE_DEFAULT    default first byte of every frame
//   FRAME_LEN_BASE      frame length without the optional CRC byte
//   CRC8_POLY           CRC-8 polynomial used when TRACE_CRC8_EN is defined
//   OFS_PT/KEY/CT       byte index where each 16-byte field starts in the frame
//   crc8_step()         one byte of MSB-first CRC-8, no reflection
//   pick_byte()         byte sel of a 128-bit vector, MSB byte first
package aes_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN_BASE   = 51;
  localparam logic [7:0] CRC8_POLY        = 8'h07;

  localparam logic [5:0] OFS_PT  = 6'd3;
  localparam logic [5:0] OFS_KEY = 6'd19;
  localparam logic [5:0] OFS_CT  = 6'd35;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  // Shifting by whole bytes keeps the selected byte at the top, which
  // avoids a variable part-select on the 128-bit vector.
  function automatic logic [7:0] pick_byte(input logic [127:0] vec, input logic [3:0] sel);
    logic [127:0] shifted;
    shifted = vec << {sel, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/aes_trace_framer_if.sv
// aes_trace_framer_if: groups the AES core handshake and the TX byte stream.
//   aes_start/aes_pt/aes_key   framer -> AES core request
//   aes_done/aes_ct            AES core -> framer result
//   tx_data/tx_valid/tx_last   framer -> TX driver byte stream
//   tx_ready                   TX driver -> framer acceptance
// modport master: the framer side; modport slave: the AES core / TX driver side.
interface aes_trace_framer_if;

  logic         aes_start;
  logic [127:0] aes_pt;
  logic [127:0] aes_key;
  logic         aes_done;
  logic [127:0] aes_ct;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;

  modport master (
    output aes_start, aes_pt, aes_key, tx_data, tx_valid, tx_last,
    input  aes_done, aes_ct, tx_ready
  );

  modport slave (
    input  aes_start, aes_pt, aes_key, tx_data, tx_valid, tx_last,
    output aes_done, aes_ct, tx_ready
  );

endinterface

// File: rtl/aes_trace_crc8.sv
// aes_trace_crc8: byte-serial CRC-8 (poly 0x07, init 0x00, MSB first).
//   clk, reset   clock and asynchronous active-low reset
//   clear        restart the CRC at 0x00 (wins over update)
//   update       fold data into the running CRC this cycle
//   data         byte to fold in
//   crc          CRC over all bytes folded in since the last clear
module aes_trace_crc8
  import aes_trace_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // Running CRC register; one byte per update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (update) begin
      crc <= crc8_step(crc, data);
    end
  end

endmodule

// File: rtl/aes_trace_framer.sv
// aes_trace_framer: hands each generator vector to the AES core and streams
// plaintext, key and ciphertext as one byte frame to the Ethernet TX driver.
//   clk, reset            clock and asynchronous active-low reset
//   trig                  vector-ready level; only its rising edge matters
//   data_in, key_in       plaintext and key from the generator
//   bus (master)          AES start/done handshake and TX valid/ready stream
//   busy                  high whenever the framer is not IDLE
//   frame_cnt             frames fully sent (wraps)
//   drop_cnt              trigger edges ignored while busy (saturates)
//   timeout_cnt           AES requests abandoned after TIMEOUT_CYCLES (saturates)
// Frame: HDR_BYTE, frame_cnt hi, frame_cnt lo, 16 B pt, 16 B key, 16 B ct.
// Build option TRACE_CRC8_EN appends a CRC-8 of bytes 0..50 as byte 51.
module aes_trace_framer
  import aes_trace_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic [127:0]        data_in,
  input  logic [127:0]        key_in,
  aes_trace_framer_if.master  bus,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         timeout_cnt
);

`ifdef TRACE_CRC8_EN
  localparam int         FRAME_LEN = FRAME_LEN_BASE + 1;
  localparam logic [5:0] CRC_IDX   = 6'(FRAME_LEN_BASE);
`else
  localparam int         FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [5:0]  LAST_IDX     = 6'(FRAME_LEN - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state, state_nx;
  logic         trig_d;
  logic         aes_start_q;
  logic [127:0] pt_q, key_q, ct_q;
  logic [5:0]   byte_idx;
  logic [15:0]  timer;
  logic         trig_edge, in_send, byte_fire;
  logic         accept, done_hit, timeout_hit, frame_done;
  logic [7:0]   frame_byte;

  assign trig_edge = trig & ~trig_d;
  assign in_send   = (state == SEND);
  assign byte_fire = in_send & bus.tx_ready;
  assign busy      = (state != IDLE);

  assign bus.aes_start = aes_start_q;
  assign bus.aes_pt    = pt_q;
  assign bus.aes_key   = key_q;

  // Stream outputs decode straight from state so an async reset drops
  // tx_valid at once; they only change on a clock edge otherwise.
  assign bus.tx_valid = in_send;
  assign bus.tx_data  = in_send ? frame_byte : 8'h00;
  assign bus.tx_last  = in_send && (byte_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A done in the last WAIT cycle still wins over timeout.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (bus.aes_done) begin
          done_hit = 1'b1;
          state_nx = SEND;
        end else if (timer == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end
      end
      SEND: begin
        if (byte_fire && (byte_idx == LAST_IDX)) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef TRACE_CRC8_EN
  logic [7:0] crc_byte;

  aes_trace_crc8 u_crc8 (
    .clk    (clk),
    .reset  (reset),
    .clear  (done_hit),
    .update (byte_fire && (byte_idx != CRC_IDX)),
    .data   (frame_byte),
    .crc    (crc_byte)
  );
`endif

  // Byte mux over the frame layout; the header carries the count before
  // this frame is credited.
  always_comb begin
    frame_byte = 8'h00;
    if (byte_idx == 6'd0)
      frame_byte = HDR_BYTE;
    else if (byte_idx == 6'd1)
      frame_byte = frame_cnt[15:8];
    else if (byte_idx == 6'd2)
      frame_byte = frame_cnt[7:0];
    else if (byte_idx < OFS_KEY)
      frame_byte = pick_byte(pt_q, 4'(byte_idx - OFS_PT));
    else if (byte_idx < OFS_CT)
      frame_byte = pick_byte(key_q, 4'(byte_idx - OFS_KEY));
`ifdef TRACE_CRC8_EN
    else if (byte_idx < CRC_IDX)
      frame_byte = pick_byte(ct_q, 4'(byte_idx - OFS_CT));
    else
      frame_byte = crc_byte;
`else
    else
      frame_byte = pick_byte(ct_q, 4'(byte_idx - OFS_CT));
`endif
  end

  // Datapath: edge detect, request latching, WAIT timer, byte index, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_d      <= 1'b0;
      aes_start_q <= 1'b0;
      pt_q        <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      byte_idx    <= '0;
      timer       <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      trig_d      <= trig;
      aes_start_q <= accept;
      if (accept) begin
        pt_q  <= data_in;
        key_q <= key_in;
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 16'd1;
      end
      if (done_hit) begin
        ct_q     <= bus.aes_ct;
        byte_idx <= '0;
      end else if (frame_done) begin
        byte_idx <= '0;
      end else if (byte_fire) begin
        byte_idx <= byte_idx + 6'd1;
      end
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
      if (trig_edge && busy && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (timeout_hit && (timeout_cnt != 16'hFFFF))
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_trace_framer.sv
// tb_aes_trace_framer: self-checking bench for aes_trace_framer.
// A scenario table plus randomized vectors drive the generator side; a small
// AES core model answers after a chosen latency (0 = never), a TX driver model
// applies random backpressure, and a monitor collects accepted bytes.
// Expected frames are built from the frame layout rules; with TRACE_CRC8_EN the
// reference CRC-8 is computed bit by bit over the expected bytes.
module tb_aes_trace_framer;

  localparam int TIMEOUT = 20;
`ifdef TRACE_CRC8_EN
  localparam int FLEN = 52;
`else
  localparam int FLEN = 51;
`endif

  localparam logic [127:0] PT0  = 128'h205B1175E79D33AADE05CE92B7A8CDC7;
  localparam logic [127:0] KEY0 = 128'h5C9D5DDD1448A9F58A8E7BBC0273C007;
  localparam logic [127:0] CT0  = 128'h0123456789ABCDEF0123456789ABCDEF;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           latency;
    int           ready_pct;
    int           hold;
    bit           trig_in_wait;
    bit           trig_in_send;
    bit           exp_frame;
    int           exp_drops;
    int           exp_timeouts;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         trig = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic [15:0]  frame_cnt, drop_cnt, timeout_cnt;

  aes_trace_framer_if bus();

  aes_trace_framer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .trig        (trig),
    .data_in     (data_in),
    .key_in      (key_in),
    .bus         (bus),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           ready_pct = 100;
  int           aes_latency = 0;
  logic [127:0] ct_val = '0;
  bit           aes_toggle = 1'b1;
  int           countdown = 0;
  int           start_count = 0;
  int           done_cyc = -1;
  int           first_valid_cyc = -1;
  int           valid_cycles = 0;
  byte_q_t      rx_bytes;
  bit           rx_last[$];
  logic [15:0]  m_frames = '0;
  logic [15:0]  m_drops = '0;
  logic [15:0]  m_tos = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] ref_crc8(input byte_q_t msg);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = r << 1;
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  task automatic build_frame(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input logic [15:0] fc,
                             output byte_q_t f);
    logic [127:0] fields[3];
    fields[0] = pt;
    fields[1] = key;
    fields[2] = ct;
    f = {};
    f.push_back(8'hA5);
    f.push_back(fc[15:8]);
    f.push_back(fc[7:0]);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        f.push_back(fields[k][127-8*i -: 8]);
    if (FLEN == 52) f.push_back(ref_crc8(f));
  endtask

  // AES core model: answers latency cycles after seeing aes_start; garbage on aes_ct otherwise.
  initial begin
    bus.aes_done = 1'b0;
    bus.aes_ct   = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.aes_done = 1'b0;
      bus.aes_ct   = rnd128();
      if (aes_toggle) begin
        bus.aes_done = 1'($urandom_range(1));
      end else if (bus.aes_start) begin
        start_count++;
        countdown = aes_latency;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.aes_done = 1'b1;
          bus.aes_ct   = ct_val;
          done_cyc     = cyc;
        end
      end
    end
  end

  // TX driver model: random ready with the current acceptance percentage.
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: samples what the next rising edge will see, collects accepted bytes, checks stall stability.
  initial begin
    bit         pv;
    logic [7:0] pd;
    logic       pl;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        pv = 1'b0;
      end else begin
        if (pv) checkOutput("stall_hold", {bus.tx_valid, bus.tx_last, bus.tx_data}, {1'b1, pl, pd});
        if (bus.tx_valid) begin
          valid_cycles++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (bus.tx_valid && bus.tx_ready) begin
          rx_bytes.push_back(bus.tx_data);
          rx_last.push_back(bus.tx_last);
        end
        pv = bus.tx_valid && !bus.tx_ready;
        pd = bus.tx_data;
        pl = bus.tx_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input vec_t v);
    byte_q_t     exp_f;
    int          base_starts, n, last_pos, n_last;
    logic [15:0] hdr_cnt;
    hdr_cnt = m_frames;
    @(negedge clk);
    ready_pct       = v.ready_pct;
    aes_latency     = v.latency;
    ct_val          = v.ct;
    data_in         = v.pt;
    key_in          = v.key;
    rx_bytes        = {};
    rx_last         = {};
    valid_cycles    = 0;
    first_valid_cyc = -1;
    done_cyc        = -1;
    base_starts     = start_count;
    trig            = 1'b1;
    @(negedge clk);
    checkOutput("start_pulse", {bus.aes_start, busy}, 2'b11);
    checkOutput("aes_pt", bus.aes_pt, v.pt);
    checkOutput("aes_key", bus.aes_key, v.key);
    data_in = rnd128();
    key_in  = rnd128();
    @(negedge clk);
    checkOutput("start_one_cycle", bus.aes_start, 1'b0);
    for (int i = 2; i < v.hold; i++) @(negedge clk);
    trig = 1'b0;
    if (v.trig_in_wait) begin
      @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
    end
    if (v.trig_in_send) begin
      n = 0;
      while (!bus.tx_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput("reach_send", bus.tx_valid, 1'b1);
      repeat (3) @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
    end
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_release", busy, 1'b0);
    repeat (10) @(negedge clk);
    if (v.exp_frame) m_frames = m_frames + 16'd1;
    m_drops = m_drops + 16'(v.exp_drops);
    m_tos   = m_tos + 16'(v.exp_timeouts);
    checkOutput("tx_idle", {bus.tx_valid, bus.tx_last, bus.tx_data}, 10'd0);
    checkOutput("start_count", start_count - base_starts, 1);
    checkOutput("frame_cnt", frame_cnt, m_frames);
    checkOutput("drop_cnt", drop_cnt, m_drops);
    checkOutput("timeout_cnt", timeout_cnt, m_tos);
    checkOutput("pt_hold", bus.aes_pt, v.pt);
    checkOutput("key_hold", bus.aes_key, v.key);
    if (v.exp_frame) begin
      build_frame(v.pt, v.key, v.ct, hdr_cnt, exp_f);
      checkOutput("frame_len", rx_bytes.size(), exp_f.size());
      for (int i = 0; i < exp_f.size(); i++)
        if (i < rx_bytes.size()) checkOutput($sformatf("byte%0d", i), rx_bytes[i], exp_f[i]);
      last_pos = -1;
      n_last   = 0;
      foreach (rx_last[i]) if (rx_last[i]) begin
        n_last++;
        last_pos = i;
      end
      checkOutput("tx_last_pos", last_pos, FLEN - 1);
      checkOutput("tx_last_once", n_last, 1);
      checkOutput("valid_latency", first_valid_cyc, done_cyc + 1);
    end else begin
      checkOutput("no_frame", valid_cycles, 0);
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t rv;
    int   n;
    tbl[0] = '{PT0, KEY0, CT0, 10, 100, 5, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[1] = '{PT0, KEY0, CT0, 10, 50, 5, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[2] = '{PT0, KEY0, CT0, 10, 100, 5, 1'b1, 1'b1, 1'b1, 2, 0};
    tbl[3] = '{PT0, KEY0, CT0, 0, 100, 40, 1'b0, 1'b0, 1'b0, 0, 1};
    tbl[4] = '{rnd128(), rnd128(), rnd128(), 19, 70, 5, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[5] = '{rnd128(), rnd128(), rnd128(), 20, 100, 5, 1'b0, 1'b0, 1'b0, 0, 1};
    tbl[6] = '{rnd128(), rnd128(), rnd128(), 1, 30, 6, 1'b0, 1'b0, 1'b1, 0, 0};

    reset      = 1'b0;
    aes_toggle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trig = ~trig;
      checkOutput("rst_ctrl", {busy, bus.tx_valid, bus.tx_last, bus.aes_start}, 4'd0);
      checkOutput("rst_data", bus.tx_data, 8'd0);
      checkOutput("rst_cnt", {frame_cnt, drop_cnt, timeout_cnt}, 48'd0);
      checkOutput("rst_pt", bus.aes_pt, 128'd0);
      checkOutput("rst_key", bus.aes_key, 128'd0);
    end
    @(negedge clk);
    trig       = 1'b0;
    aes_toggle = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst", {busy, bus.tx_valid}, 2'b00);

    for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv.pt           = rnd128();
      rv.key          = rnd128();
      rv.ct           = rnd128();
      rv.latency      = $urandom_range(24, 1);
      rv.ready_pct    = $urandom_range(100, 25);
      rv.hold         = $urandom_range(6, 2);
      rv.trig_in_wait = 1'b0;
      rv.trig_in_send = 1'b0;
      rv.exp_frame    = (rv.latency <= TIMEOUT - 1);
      rv.exp_drops    = 0;
      rv.exp_timeouts = rv.exp_frame ? 0 : 1;
      applyStimulus(rv);
    end

    @(negedge clk);
    ready_pct   = 100;
    aes_latency = 10;
    ct_val      = CT0;
    data_in     = PT0;
    key_in      = KEY0;
    rx_bytes    = {};
    rx_last     = {};
    trig        = 1'b1;
    repeat (5) @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (rx_bytes.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_byte10", rx_bytes.size(), 10);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_tx_valid", {bus.tx_valid, busy}, 2'b00);
    checkOutput("rst_frame_cnt", frame_cnt, 16'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    m_frames = '0;
    m_drops  = '0;
    m_tos    = '0;
    valid_cycles = 0;
    repeat (60) @(negedge clk);
    checkOutput("no_resume", valid_cycles, 0);
    checkOutput("frame_cnt_after_rst", frame_cnt, 16'd0);

    applyStimulus(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
